// File: rtl/param_boot_loader_if.sv
// RAM-side bus of the boot loader: one-cycle strobe, read data one cycle later.
interface param_boot_loader_if #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 8
);
    logic [DATA_W-1:0] ram_out;
    logic [DATA_W-1:0] ram_in;
    logic [ADDR_W-1:0] ram_adr;
    logic              ram_rw;
    logic              ram_enable;

    modport master (
        input  ram_out,
        output ram_in,
        output ram_adr,
        output ram_rw,
        output ram_enable
    );

    modport slave (
        output ram_out,
        input  ram_in,
        input  ram_adr,
        input  ram_rw,
        input  ram_enable
    );
endinterface

// File: rtl/param_boot_loader.sv
// UART boot loader: loads a RAM image over 8N1 rx, acks a checksum, dumps RAM on request.
module param_boot_loader #(
    parameter int unsigned CLK_DIV = 868,
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned ADDR_W  = 8,
    parameter int unsigned DEPTH   = 256
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 ce,
    input  logic                 rx,
    input  logic                 scan_memory,
    output logic                 tx,
    output logic                 boot,
    param_boot_loader_if.master  bus
);
    localparam int unsigned BPW  = DATA_W / 8;
    localparam int unsigned CNT_W = $clog2(CLK_DIV);
    localparam int unsigned BC_W = (BPW > 1) ? $clog2(BPW) : 1;

    typedef enum logic [2:0] {LOAD, ACK, RUN, SCAN_STB, SCAN_CAP, SCAN_TX} state_t;

    // ---------------- RX ----------------
    logic             rx_s1, rx_s2, rx_d;
    logic             rx_busy;
    logic [CNT_W-1:0] rx_cnt;
    logic [3:0]       rx_bit;
    logic [7:0]       rx_sh;
    logic             rx_tick_c, byte_ok_c;

    assign rx_tick_c = rx_busy && (rx_cnt == ((rx_bit == 4'd0) ? CNT_W'(CLK_DIV / 2 - 1)
                                                                : CNT_W'(CLK_DIV - 1)));
    assign byte_ok_c = rx_tick_c && (rx_bit == 4'd9) && rx_s2;

    // Two-flop synchroniser plus one delay stage for falling-edge detection
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_s1 <= 1'b1;
            rx_s2 <= 1'b1;
            rx_d  <= 1'b1;
        end else if (ce) begin
            rx_s1 <= rx;
            rx_s2 <= rx_s1;
            rx_d  <= rx_s2;
        end
    end

    // Frame receiver: start re-check at half bit, then 8 data bits and stop
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_busy <= 1'b0;
            rx_cnt  <= '0;
            rx_bit  <= '0;
            rx_sh   <= '0;
        end else if (ce) begin
            if (!rx_busy) begin
                if (rx_d && !rx_s2) begin
                    rx_busy <= 1'b1;
                    rx_cnt  <= '0;
                    rx_bit  <= '0;
                end
            end else if (rx_tick_c) begin
                rx_cnt <= '0;
                if ((rx_bit == 4'd0 && rx_s2) || rx_bit == 4'd9) begin
                    rx_busy <= 1'b0;
                end else begin
                    if (rx_bit != 4'd0) rx_sh <= {rx_s2, rx_sh[7:1]};
                    rx_bit <= rx_bit + 4'd1;
                end
            end else begin
                rx_cnt <= rx_cnt + CNT_W'(1);
            end
        end
    end

    // ---------------- TX ----------------
    logic             tx_busy;
    logic [CNT_W-1:0] tx_cnt;
    logic [3:0]       tx_bits;
    logic [8:0]       tx_sh;
    logic             tx_done_c, tx_start_c;
    logic [7:0]       tx_byte_c;

    assign tx_done_c = tx_busy && (tx_cnt == CNT_W'(CLK_DIV - 1)) && (tx_bits == 4'd0);

    // Frame transmitter; a start in the done cycle gives back-to-back frames
    always_ff @(posedge clk) begin
        if (rst) begin
            tx      <= 1'b1;
            tx_busy <= 1'b0;
            tx_cnt  <= '0;
            tx_bits <= '0;
            tx_sh   <= '1;
        end else if (ce) begin
            if (tx_start_c) begin
                tx      <= 1'b0;
                tx_sh   <= {1'b1, tx_byte_c};
                tx_bits <= 4'd9;
                tx_cnt  <= '0;
                tx_busy <= 1'b1;
            end else if (tx_busy) begin
                if (tx_cnt == CNT_W'(CLK_DIV - 1)) begin
                    tx_cnt <= '0;
                    if (tx_bits == 4'd0) begin
                        tx_busy <= 1'b0;
                    end else begin
                        tx      <= tx_sh[0];
                        tx_sh   <= {1'b1, tx_sh[8:1]};
                        tx_bits <= tx_bits - 4'd1;
                    end
                end else begin
                    tx_cnt <= tx_cnt + CNT_W'(1);
                end
            end
        end
    end

    // ---------------- Control ----------------
    state_t            state, state_nxt;
    logic [ADDR_W-1:0] adr, adr_nxt;
    logic [BC_W-1:0]   bcnt, bcnt_nxt;
    logic [DATA_W-1:0] word, word_nxt;
    logic [7:0]        csum, csum_nxt;
    logic              scan_prev, scan_prev_nxt, boot_nxt;
    logic [DATA_W-1:0] ram_in_nxt;
    logic [ADDR_W-1:0] ram_adr_nxt;
    logic              ram_rw_nxt, ram_enable_nxt;

    // Control state and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= LOAD;
            adr            <= '0;
            bcnt           <= '0;
            word           <= '0;
            csum           <= '0;
            scan_prev      <= 1'b0;
            boot           <= 1'b1;
            bus.ram_in     <= '0;
            bus.ram_adr    <= '0;
            bus.ram_rw     <= 1'b0;
            bus.ram_enable <= 1'b0;
        end else if (ce) begin
            state          <= state_nxt;
            adr            <= adr_nxt;
            bcnt           <= bcnt_nxt;
            word           <= word_nxt;
            csum           <= csum_nxt;
            scan_prev      <= scan_prev_nxt;
            boot           <= boot_nxt;
            bus.ram_in     <= ram_in_nxt;
            bus.ram_adr    <= ram_adr_nxt;
            bus.ram_rw     <= ram_rw_nxt;
            bus.ram_enable <= ram_enable_nxt;
        end
    end

    // Next-state and output decode for load / ack / run / scan
    always_comb begin
        state_nxt      = state;
        adr_nxt        = adr;
        bcnt_nxt       = bcnt;
        word_nxt       = word;
        csum_nxt       = csum;
        scan_prev_nxt  = scan_memory;
        boot_nxt       = boot;
        ram_in_nxt     = bus.ram_in;
        ram_adr_nxt    = bus.ram_adr;
        ram_rw_nxt     = 1'b0;
        ram_enable_nxt = 1'b0;
        tx_start_c     = 1'b0;
        tx_byte_c      = 8'h00;
        case (state)
            LOAD: begin
                if (byte_ok_c) begin
                    csum_nxt = csum + rx_sh;
                    word_nxt = DATA_W'({rx_sh, word} >> 8);
                    if (bcnt == BC_W'(BPW - 1)) begin
                        bcnt_nxt       = '0;
                        ram_enable_nxt = 1'b1;
                        ram_rw_nxt     = 1'b1;
                        ram_adr_nxt    = adr;
                        ram_in_nxt     = word_nxt;
                        if (adr == ADDR_W'(DEPTH - 1)) begin
                            state_nxt  = ACK;
                            tx_start_c = 1'b1;
                            tx_byte_c  = csum_nxt;
                        end else begin
                            adr_nxt = adr + ADDR_W'(1);
                        end
                    end else begin
                        bcnt_nxt = bcnt + BC_W'(1);
                    end
                end
            end
            ACK: begin
                if (tx_done_c) begin
                    boot_nxt  = 1'b0;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (scan_memory && !scan_prev) begin
                    adr_nxt        = '0;
                    ram_adr_nxt    = '0;
                    ram_enable_nxt = 1'b1;
                    state_nxt      = SCAN_STB;
                end
            end
            SCAN_STB: state_nxt = SCAN_CAP;
            SCAN_CAP: begin
                word_nxt   = bus.ram_out;
                bcnt_nxt   = '0;
                tx_start_c = 1'b1;
                tx_byte_c  = bus.ram_out[7:0];
                state_nxt  = SCAN_TX;
            end
            SCAN_TX: begin
                if (tx_done_c) begin
                    if (bcnt == BC_W'(BPW - 1)) begin
                        if (adr == ADDR_W'(DEPTH - 1)) begin
                            state_nxt = RUN;
                        end else begin
                            adr_nxt        = adr + ADDR_W'(1);
                            ram_adr_nxt    = adr + ADDR_W'(1);
                            ram_enable_nxt = 1'b1;
                            state_nxt      = SCAN_STB;
                        end
                    end else begin
                        bcnt_nxt   = bcnt + BC_W'(1);
                        word_nxt   = DATA_W'(word >> 8);
                        tx_start_c = 1'b1;
                        tx_byte_c  = word_nxt[7:0];
                    end
                end
            end
            default: state_nxt = LOAD;
        endcase
    end
endmodule
